mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
// Per-requester stall outputs feed the hazard detection unit, which freezes PC and the pipeline registers.
// The stalls are kept alongside the load-use and branch-flush conditions already handled there.
// Read data returns a fixed MEM_LATENCY cycles after the memory enable pulse.
// PARAMETERS
// ADDR_W       32  address width, IF and MEM ports
// DATA_W       32  data width
// MEM_LATENCY  2   cycles from m_en to valid m_rdata; must be >= 1
// PORTS
// clk       in   1       clock; all state updates on posedge
// reset     in   1       synchronous, active-high
// if_req    in   1       fetch request; held until if_valid or if_flush
// if_addr   in   ADDR_W  fetch address; stable while if_req
// if_flush  in   1       taken branch: drop the in-flight or pending fetch
// if_rdata  out  DATA_W  instruction; valid only with if_valid
// if_valid  out  1       one-cycle fetch completion pulse
// d_req     in   1       data request; held until d_valid
// d_we      in   1       1 = store, 0 = load; stable while d_req
// d_addr    in   ADDR_W  data address
// d_wdata   in   DATA_W  store data
// d_rdata   out  DATA_W  load data; valid only with d_valid
// d_valid   out  1       one-cycle data completion pulse
// m_en      out  1       memory access strobe, exactly one cycle per access
// m_we      out  1       memory write enable; qualified by m_en
// m_addr    out  ADDR_W  memory address
// m_wdata   out  DATA_W  memory write data
// m_rdata   in   DATA_W  memory read data, valid MEM_LATENCY cycles after m_en
// stall_if  out  1       if_req && !if_valid && !if_flush
// stall_mem out  1       d_req && !d_valid
// BEHAVIOUR
// - Reset: state=IDLE, cnt=0, owner=NONE, drop=0. All outputs 0 while reset is high.
// - Reset mid-access: the transaction is abandoned. No valid pulse; a late m_rdata is ignored.
// - FSM states: IDLE, BUSY_D, BUSY_I.
// - IDLE: grant cycle G. Data has priority over fetch, because MEM holds the older instruction.
//   - d_req: m_en=1, m_we=d_we, m_addr/m_wdata from the d_* inputs. Go to BUSY_D.
//   - Else if_req && !if_flush: m_en=1, m_we=0, m_addr=if_addr. Go to BUSY_I.
//   - Counter load: cnt = MEM_LATENCY for reads, 1 for stores.
// - m_en, m_we, m_addr and m_wdata are driven combinationally only in grant cycles. Otherwise all 0.
// - BUSY_x: cnt decrements every cycle.
//   - At cnt==1, the valid pulse is asserted and the FSM returns to IDLE at the next edge.
//   - *_rdata = m_rdata (pass-through) in the valid cycle and 0 otherwise. For stores, d_rdata=0.
// - Latency: a load or fetch granted in cycle G pulses valid in cycle G+MEM_LATENCY. A store pulses in G+1.
// - The next grant is possible in the cycle after valid. Throughput is 1 access per MEM_LATENCY+1 cycles.
// - Starvation: IF waits while d_req is continuously asserted. This is legal, since MEM requests are finite.
// - if_flush during BUSY_I: set drop=1. The access still runs to completion on the memory side.
//   - if_valid is suppressed in the completion cycle, and drop clears on return to IDLE.
// - if_flush in IDLE: the fetch is not granted that cycle.
// - if_flush and d_req together: d_req is granted normally.
// - if_flush in BUSY_D: no effect on the data access. The pending fetch is simply re-requested later.
// - Requester drops its req mid-access (other than IF via flush): protocol violation; behaviour is undefined.
// - stall_if is forced to 0 in the if_flush cycle, so PC can load the branch target.
// - cnt width is $clog2(MEM_LATENCY+1). cnt never wraps, because it is only loaded in IDLE.
// TESTING
// 1 Fetch, MEM_LATENCY=2: if_req=1, if_addr=0x40 at cycle 0, m_rdata=0x00500093 at cycle 2
//   -> m_en only at cycle 0, if_valid only at cycle 2, if_rdata=0x00500093.
//   -> stall_if=1 in cycles 0-1.
// 2 Contention: if_req and d_req (load 0x100) both asserted in cycle 0
//   -> data granted at 0, d_valid at 2.
//   -> fetch granted at 3, if_valid at 5; stall_if high in cycles 0-4.
// 3 Store: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF
//   -> m_en=1, m_we=1 with those values in cycle 0.
//   -> d_valid in cycle 1, next grant possible in cycle 2.
// 4 Flush: fetch granted at 0, if_flush=1 at 1
//   -> no if_valid at 2, stall_if=0 in cycle 1.
//   -> a new if_req at 3 is granted at 3, if_valid at 5.
// 5 Reset mid-load: load granted at 0, reset=1 at 1
//   -> all outputs 0 during reset, no d_valid at 2.
//   -> after reset, IDLE with first grant on the next request.
// 6 MEM_LATENCY=1 back-to-back loads
//   -> m_en in cycles 0, 2, 4 and d_valid in cycles 1, 3, 5.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and load/store (MEM).
// Data requests win over fetches. Read data returns a fixed MEM_LATENCY cycles after the grant.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               drop_q, drop_d;
  logic               store_q, store_d;

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      store_q <= store_d;
    end
  end

  // Grant, countdown and completion; memory strobes only in the grant cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    store_d   = store_q;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    if_valid  = 1'b0;
    d_valid   = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;

    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (d_req) begin
          m_en    = 1'b1;
          m_we    = d_we;
          m_addr  = d_addr;
          m_wdata = d_wdata;
          store_d = d_we;
          cnt_d   = d_we ? CNT_W'(1) : CNT_W'(MEM_LATENCY);
          state_d = BUSY_D;
        end else if (if_req && !if_flush) begin
          m_en    = 1'b1;
          m_addr  = if_addr;
          store_d = 1'b0;
          cnt_d   = CNT_W'(MEM_LATENCY);
          state_d = BUSY_I;
        end
      end
      BUSY_D: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          d_valid = 1'b1;
          d_rdata = store_q ? '0 : m_rdata;
          state_d = IDLE;
        end
      end
      BUSY_I: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (if_flush) drop_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          // A flush in the completion cycle itself also kills the pulse.
          if (!drop_q && !if_flush) begin
            if_valid = 1'b1;
            if_rdata = m_rdata;
          end
          drop_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    stall_if  = if_req && !if_valid && !if_flush;
    stall_mem = d_req && !d_valid;

    // Everything the arbiter drives is quiet while reset is held.
    if (reset) begin
      m_en      = 1'b0;
      m_we      = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      if_valid  = 1'b0;
      d_valid   = 1'b0;
      if_rdata  = '0;
      d_rdata   = '0;
      stall_if  = 1'b0;
      stall_mem = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LATENCY=2 instance for most scenarios,
// MEM_LATENCY=1 instance for back-to-back throughput.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req, if_flush, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;

  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_valid, d_valid, m_en, m_we, stall_if, stall_mem;

  logic [31:0] if_rdata1, d_rdata1, m_addr1, m_wdata1;
  logic        if_valid1, d_valid1, m_en1, m_we1, stall_if1, stall_mem1;

  int n_cmp;
  int n_bad;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata1), .if_valid(if_valid1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata1), .d_valid(d_valid1),
    .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
    .m_rdata(m_rdata), .stall_if(stall_if1), .stall_mem(stall_mem1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs for the new cycle are set next.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_flush = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    reset = 1;

    // Reset: everything quiet even with requests present.
    next_cycle();
    if_req = 1; d_req = 1; #1;
    chk("rst_m_en", m_en, 0);
    chk("rst_stall_if", stall_if, 0);
    chk("rst_stall_mem", stall_mem, 0);
    next_cycle();
    idle_inputs(); reset = 0; #1;
    chk("post_rst_m_en", m_en, 0);

    // 1: single fetch, valid at G+2.
    next_cycle();
    if_req = 1; if_addr = 32'h40; #1;
    chk("t1_c0_m_en", m_en, 1);
    chk("t1_c0_m_we", m_we, 0);
    chk("t1_c0_m_addr", m_addr, 32'h40);
    chk("t1_c0_stall_if", stall_if, 1);
    next_cycle(); #1;
    chk("t1_c1_m_en", m_en, 0);
    chk("t1_c1_if_valid", if_valid, 0);
    chk("t1_c1_stall_if", stall_if, 1);
    next_cycle();
    m_rdata = 32'h00500093; #1;
    chk("t1_c2_if_valid", if_valid, 1);
    chk("t1_c2_if_rdata", if_rdata, 32'h00500093);
    chk("t1_c2_stall_if", stall_if, 0);
    next_cycle();
    idle_inputs(); #1;
    chk("t1_c3_if_valid", if_valid, 0);
    chk("t1_c3_if_rdata", if_rdata, 0);

    // 2: contention, data first then fetch.
    next_cycle();
    if_req = 1; if_addr = 32'h44; d_req = 1; d_addr = 32'h100; #1;
    chk("t2_c0_m_addr", m_addr, 32'h100);
    chk("t2_c0_m_en", m_en, 1);
    chk("t2_c0_stall_if", stall_if, 1);
    chk("t2_c0_stall_mem", stall_mem, 1);
    next_cycle(); #1;
    chk("t2_c1_m_en", m_en, 0);
    next_cycle();
    m_rdata = 32'h11112222; #1;
    chk("t2_c2_d_valid", d_valid, 1);
    chk("t2_c2_d_rdata", d_rdata, 32'h11112222);
    chk("t2_c2_if_valid", if_valid, 0);
    chk("t2_c2_stall_mem", stall_mem, 0);
    chk("t2_c2_stall_if", stall_if, 1);
    next_cycle();
    d_req = 0; d_addr = 0; m_rdata = 0; #1;
    chk("t2_c3_m_en", m_en, 1);
    chk("t2_c3_m_addr", m_addr, 32'h44);
    chk("t2_c3_d_valid", d_valid, 0);
    next_cycle(); #1;
    chk("t2_c4_stall_if", stall_if, 1);
    next_cycle();
    m_rdata = 32'h33334444; #1;
    chk("t2_c5_if_valid", if_valid, 1);
    chk("t2_c5_if_rdata", if_rdata, 32'h33334444);
    chk("t2_c5_d_rdata", d_rdata, 0);
    next_cycle();
    idle_inputs(); #1;

    // 3: store completes at G+1 with zero read data; next grant at G+2.
    next_cycle();
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; #1;
    chk("t3_c0_m_en", m_en, 1);
    chk("t3_c0_m_we", m_we, 1);
    chk("t3_c0_m_addr", m_addr, 32'h200);
    chk("t3_c0_m_wdata", m_wdata, 32'hDEADBEEF);
    next_cycle();
    m_rdata = 32'hFFFFFFFF; #1;
    chk("t3_c1_d_valid", d_valid, 1);
    chk("t3_c1_d_rdata", d_rdata, 0);
    chk("t3_c1_m_en", m_en, 0);
    next_cycle();
    idle_inputs(); if_req = 1; if_addr = 32'h48; #1;
    chk("t3_c2_m_en", m_en, 1);
    chk("t3_c2_m_addr", m_addr, 32'h48);
    chk("t3_c2_m_wdata", m_wdata, 0);
    next_cycle(); #1;
    next_cycle(); m_rdata = 32'h0000ABCD; #1;
    chk("t3_c4_if_valid", if_valid, 1);
    next_cycle();
    idle_inputs(); #1;

    // 4: flush an in-flight fetch, then refetch.
    next_cycle();
    if_req = 1; if_addr = 32'h80; #1;
    chk("t4_c0_m_en", m_en, 1);
    next_cycle();
    if_flush = 1; #1;
    chk("t4_c1_stall_if", stall_if, 0);
    chk("t4_c1_m_en", m_en, 0);
    next_cycle();
    if_flush = 0; if_req = 0; m_rdata = 32'hAAAA5555; #1;
    chk("t4_c2_if_valid", if_valid, 0);
    chk("t4_c2_if_rdata", if_rdata, 0);
    next_cycle();
    m_rdata = 0; if_req = 1; if_addr = 32'h90; #1;
    chk("t4_c3_m_en", m_en, 1);
    chk("t4_c3_m_addr", m_addr, 32'h90);
    next_cycle(); #1;
    next_cycle(); m_rdata = 32'h12345678; #1;
    chk("t4_c5_if_valid", if_valid, 1);
    chk("t4_c5_if_rdata", if_rdata, 32'h12345678);
    next_cycle();
    idle_inputs(); #1;

    // Flush in IDLE blocks the fetch; flush with d_req still grants data.
    next_cycle();
    if_req = 1; if_flush = 1; if_addr = 32'hA0; #1;
    chk("fl_idle_m_en", m_en, 0);
    chk("fl_idle_stall_if", stall_if, 0);
    d_req = 1; d_addr = 32'hB0; #1;
    chk("fl_d_m_en", m_en, 1);
    chk("fl_d_m_addr", m_addr, 32'hB0);
    next_cycle(); #1;
    next_cycle(); if_flush = 0; m_rdata = 32'h0BADF00D; #1;
    chk("fl_d_valid", d_valid, 1);
    chk("fl_if_valid", if_valid, 0);
    next_cycle();
    idle_inputs(); #1;

    // 5: reset during a load abandons it.
    next_cycle();
    d_req = 1; d_addr = 32'h300; #1;
    chk("t5_c0_m_en", m_en, 1);
    next_cycle();
    reset = 1; #1;
    chk("t5_c1_m_en", m_en, 0);
    chk("t5_c1_stall_mem", stall_mem, 0);
    chk("t5_c1_d_valid", d_valid, 0);
    next_cycle();
    m_rdata = 32'h55555555; #1;
    chk("t5_c2_d_valid", d_valid, 0);
    chk("t5_c2_d_rdata", d_rdata, 0);
    next_cycle();
    reset = 0; d_req = 0; #1;
    chk("t5_c3_d_valid", d_valid, 0);
    chk("t5_c3_m_en", m_en, 0);
    next_cycle();
    m_rdata = 0; d_req = 1; d_addr = 32'h304; #1;
    chk("t5_c4_m_en", m_en, 1);
    chk("t5_c4_m_addr", m_addr, 32'h304);
    next_cycle();
    idle_inputs(); #1;
    next_cycle(); #1;
    next_cycle(); #1;

    // 6: MEM_LATENCY=1, back-to-back loads, one access every two cycles.
    d_req = 1; d_addr = 32'h10; m_rdata = 32'h101; #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t6_c%0d_m_en", i), m_en1, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("t6_c%0d_d_valid", i), d_valid1, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 1) chk($sformatf("t6_c%0d_d_rdata", i), d_rdata1, 32'h101);
      next_cycle(); #1;
    end
    idle_inputs(); #1;
    chk("t6_c6_m_en", m_en1, 0);
    next_cycle(); #1;
    next_cycle(); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
